dm_be: RTL and testbench

Parametrised, byte-enable data memory for the five-stage pipeline's MEM stage, generalising the 32x128 `dm` block. It adds:
- a req/ready handshake;
- a registered read port with an `rvalid` strobe;
- per-byte write masks for `sb`/`sh`/`sw`;
- an optional hardware clear sweep that zeroes every entry after reset or on command.

---
 rtl/dm_be.sv | 74 +++++++
 tb/tb_dm_be.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dm_be.sv
// dm_be: byte-enable data memory with req/ready handshake, registered read port and DM_CLEAR_EN-guarded clear sweep
module dm_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              acc;
  logic              sweep;
  logic [ADDR_W-1:0] sweep_addr;
`ifdef DM_CLEAR_EN
  typedef enum logic {RUN, CLEAR} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q == RUN ? (clr ? CLEAR : RUN) : (cnt_q == '1 ? RUN : CLEAR);
    cnt_d   = state_q == CLEAR ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  assign sweep      = state_q == CLEAR;
  assign sweep_addr = cnt_q;
  assign ready      = !sweep && !clr;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign sweep      = 1'b0;
  assign sweep_addr = '0;
  assign ready      = 1'b1;
`endif
  assign busy = sweep;
  assign acc  = req && ready;
  always_comb begin
    rvalid_d = acc && !we;
    rdata_d  = acc && !we ? mem[addr] : rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  always_ff @(posedge clk)
    if (sweep)
      mem[sweep_addr] <= '0;
    else if (acc && we)
      for (int i = 0; i < BE_W; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
endmodule

// File: tb/tb_dm_be.sv
// tb_dm_be: directed self-checking bench for dm_be
module tb_dm_be;
`ifdef DM_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif
  localparam int SWEEP = CLR_EN ? 128 : 0;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, clr;
  logic [6:0]  addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready, rvalid, busy;
  logic [31:0] rdata;
  int          errors = 0;
  int          checks = 0;
  dm_be dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .clr(clr), .ready(ready), .rvalid(rvalid), .rdata(rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic acc(input logic w, input logic [6:0] a, input logic [3:0] b, input logic [31:0] d);
    int n;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    wait_ready(n);
    if (!ready) check("acc_timeout", {31'd0, ready}, 32'd1);
    @(posedge clk);
    #1 req = 1'b0; we = 1'b0;
  endtask
  task automatic wr(input string tag, input logic [6:0] a, input logic [3:0] b, input logic [31:0] d);
    logic [31:0] held;
    held = rdata;
    acc(1'b1, a, b, d);
    check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
    check({tag, "_rdata_held"}, rdata, held);
  endtask
  task automatic rd(input string tag, input logic [6:0] a, input logic [31:0] exp);
    acc(1'b0, a, 4'hF, 32'hFFFF_FFFF);
    check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    check({tag, "_rdata"}, rdata, exp);
  endtask
  initial begin
    int n;
    {req, we, clr, addr, be, wdata} = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_busy", {31'd0, busy}, {31'd0, CLR_EN});
    check("rst_ready", {31'd0, ready}, {31'd0, !CLR_EN});
    @(negedge clk) rst_n = 1'b1;
    wait_ready(n);
    check("sweep_len", n, SWEEP);
    check("post_busy", {31'd0, busy}, 32'd0);
    if (CLR_EN) begin
      rd("clr0", 7'd0, 32'd0);
      rd("clr64", 7'd64, 32'd0);
      rd("clr127", 7'd127, 32'd0);
    end
    wr("w5a", 7'd5, 4'b1111, 32'hDEAD_BEEF);
    wr("w5b", 7'd5, 4'b0101, 32'h1122_3344);
    rd("r5a", 7'd5, 32'hDE22_BE44);
    @(posedge clk);
    #1;
    check("r5a_rvalid_drop", {31'd0, rvalid}, 32'd0);
    check("r5a_rdata_hold", rdata, 32'hDE22_BE44);
    wr("w5nop", 7'd5, 4'b0000, 32'hFFFF_FFFF);
    rd("r5nop", 7'd5, 32'hDE22_BE44);
    wr("w5c", 7'd5, 4'b1010, 32'hAABB_CCDD);
    rd("r5c", 7'd5, 32'hAA22_CC44);
    wr("w9", 7'd9, 4'b1111, 32'hCAFE_F00D);
    rd("r9", 7'd9, 32'hCAFE_F00D);
    wr("w1", 7'd1, 4'b1111, 32'hA1A1_A1A1);
    wr("w2", 7'd2, 4'b1111, 32'hB2B2_B2B2);
    wr("w3", 7'd3, 4'b1111, 32'hC3C3_C3C3);
    rd("b2b1", 7'd1, 32'hA1A1_A1A1);
    rd("b2b2", 7'd2, 32'hB2B2_B2B2);
    rd("b2b3", 7'd3, 32'hC3C3_C3C3);
    @(posedge clk);
    #1 check("b2b_rvalid_drop", {31'd0, rvalid}, 32'd0);
    @(negedge clk);
    we = 1'b1; addr = 7'd5; be = 4'hF; wdata = 32'd0;
    @(posedge clk);
    #1 we = 1'b0;
    check("noreq_rvalid", {31'd0, rvalid}, 32'd0);
    rd("noreq_r5", 7'd5, 32'hAA22_CC44);
    if (!CLR_EN) begin
      @(negedge clk);
      clr = 1'b1; req = 1'b1; we = 1'b0; addr = 7'd3;
      #1 check("noclr_ready", {31'd0, ready}, 32'd1);
      @(posedge clk);
      #1 clr = 1'b0; req = 1'b0;
      check("noclr_rvalid", {31'd0, rvalid}, 32'd1);
      check("noclr_rdata", rdata, 32'hC3C3_C3C3);
      check("noclr_busy", {31'd0, busy}, 32'd0);
    end
    wr("wm", 7'd9, 4'b1111, 32'h1234_5678);
    rd("rm", 7'd9, 32'h1234_5678);
    rst_n = 1'b0;
    #1;
    check("midacc_rdata", rdata, 32'd0);
    check("midacc_rvalid", {31'd0, rvalid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    wait_ready(n);
    check("midacc_sweep_len", n, SWEEP);
    rd("midacc_r9", 7'd9, CLR_EN ? 32'd0 : 32'h1234_5678);
    if (CLR_EN) begin
      wr("ws5", 7'd5, 4'b1111, 32'h5555_AAAA);
      @(negedge clk);
      clr = 1'b1; req = 1'b1; we = 1'b0; addr = 7'd5;
      #1 check("stall_ready", {31'd0, ready}, 32'd0);
      @(posedge clk);
      #1 clr = 1'b0;
      check("stall_rvalid", {31'd0, rvalid}, 32'd0);
      check("stall_busy", {31'd0, busy}, 32'd1);
      wait_ready(n);
      check("stall_len", n, 128);
      @(posedge clk);
      #1 req = 1'b0;
      check("stall_acc_rvalid", {31'd0, rvalid}, 32'd1);
      check("stall_acc_rdata", rdata, 32'd0);
      wr("w7", 7'd7, 4'b1111, 32'h0F0F_0F0F);
      rd("r7", 7'd7, 32'h0F0F_0F0F);
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
      repeat (39) @(negedge clk);
      check("midsweep_busy", {31'd0, busy}, 32'd1);
      check("midsweep_rdata_pre", rdata, 32'h0F0F_0F0F);
      #2 rst_n = 1'b0;
      #1;
      check("midsweep_rdata", rdata, 32'd0);
      check("midsweep_rvalid", {31'd0, rvalid}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      wait_ready(n);
      check("midsweep_len", n, 128);
      rd("midsweep_r7", 7'd7, 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
